// File: rtl/bios_wd_lpc_target_if.sv
// LPC bus bundle between the host (master) and an I/O target (slave).
//   LFRAMEn : frame strobe from host, active low
//   LADIn   : LAD nibble as sampled by the target
//   LADOut  : LAD nibble driven by the target
//   LADOe   : target output enable for LAD
interface bios_wd_lpc_target_if;
  logic       LFRAMEn;
  logic [3:0] LADIn;
  logic [3:0] LADOut;
  logic       LADOe;

  modport master (output LFRAMEn, output LADIn, input LADOut, input LADOe);
  modport slave  (input LFRAMEn, input LADIn, output LADOut, output LADOe);
endinterface

// File: rtl/bios_wd_lpc_target.sv
// LPC I/O target for the BIOS watchdog control/status port.
//   LpcClock/Reset : LPC clock, synchronous active-high reset
//   lpc            : LFRAMEn/LADIn in, LADOut/LADOe out
//   DPx, BiosFinished, ForceSwap, BiosWDReset : watchdog status for host reads
//   BiosWDReg      : control byte to the watchdog (kick code self-clears)
//   BiosWDWrStrobe : one-cycle pulse per committed write
//   LastWrite      : last committed write byte, readable at ECHO_ADDR
module bios_wd_lpc_target #(
  parameter logic [15:0] BASE_ADDR  = 16'h0C80,
  parameter logic [15:0] ECHO_ADDR  = 16'h0C81,
  parameter logic [7:0]  PULSE_CODE = 8'hAA
) (
  input  logic                       LpcClock,
  input  logic                       Reset,
  bios_wd_lpc_target_if.slave        lpc,
  input  logic [1:0]                 DPx,
  input  logic                       BiosFinished,
  input  logic                       ForceSwap,
  input  logic                       BiosWDReset,
  output logic [7:0]                 BiosWDReg,
  output logic                       BiosWDWrStrobe,
  output logic [7:0]                 LastWrite
);

  localparam int unsigned CNT_W  = 2;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned NIB_W  = 4;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_CYCTYPE,
    ST_ADDR,
    ST_WDATA,
    ST_HTAR,
    ST_SYNC,
    ST_RDATA,
    ST_PTAR,
    ST_IGNORE
  } state_e;

  state_e              state_q,    state_d;
  logic [CNT_W-1:0]    cnt_q,      cnt_d;
  logic                is_wr_q,    is_wr_d;
  logic                is_echo_q,  is_echo_d;
  logic [11:0]         addr_q,     addr_d;
  logic [BYTE_W-1:0]   data_q,     data_d;
  logic                lad_oe_q,   lad_oe_d;
  logic [NIB_W-1:0]    lad_out_q,  lad_out_d;
  logic [BYTE_W-1:0]   wd_reg_q,   wd_reg_d;
  logic                strobe_q,   strobe_d;
  logic [BYTE_W-1:0]   last_q,     last_d;

  logic                frame_start;
  logic                frame_abort;
  logic [15:0]         addr_full;
  logic [BYTE_W-1:0]   status_byte;

  assign frame_start = !lpc.LFRAMEn && (lpc.LADIn == 4'h0);
  assign frame_abort = !lpc.LFRAMEn && (lpc.LADIn == 4'hF);
  assign addr_full   = {addr_q, lpc.LADIn};
  assign status_byte = {3'b000, BiosWDReset, ForceSwap, BiosFinished, DPx};

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_wr_d   = is_wr_q;
    is_echo_d = is_echo_q;
    addr_d    = addr_q;
    data_d    = data_q;
    lad_oe_d  = lad_oe_q;
    lad_out_d = lad_out_q;
    last_d    = last_q;
    strobe_d  = 1'b0;
    // The kick code is only ever shown for the single cycle after its commit.
    wd_reg_d  = (wd_reg_q == PULSE_CODE) ? 8'h00 : wd_reg_q;

    if (frame_start) begin
      state_d   = ST_CYCTYPE;
      lad_oe_d  = 1'b0;
      lad_out_d = 4'hF;
    end else if (!lpc.LFRAMEn) begin
      // ABORT goes idle; any other start code belongs to another cycle type.
      state_d   = frame_abort ? ST_IDLE : ST_IGNORE;
      lad_oe_d  = 1'b0;
      lad_out_d = 4'hF;
    end else begin
      case (state_q)
        ST_IDLE: ;
        ST_CYCTYPE: begin
          cnt_d = '0;
          if (lpc.LADIn[3:1] == 3'b000) begin
            is_wr_d = 1'b0;
            state_d = ST_ADDR;
          end else if (lpc.LADIn[3:1] == 3'b001) begin
            is_wr_d = 1'b1;
            state_d = ST_ADDR;
          end else begin
            state_d = ST_IGNORE;
          end
        end
        ST_ADDR: begin
          addr_d = {addr_q[7:0], lpc.LADIn};
          cnt_d  = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(3)) begin
            cnt_d = '0;
            if (addr_full == BASE_ADDR || addr_full == ECHO_ADDR) begin
              is_echo_d = (addr_full == ECHO_ADDR);
              state_d   = is_wr_q ? ST_WDATA : ST_HTAR;
            end else begin
              state_d = ST_IGNORE;
            end
          end
        end
        ST_WDATA: begin
          if (cnt_q == '0) begin
            data_d[3:0] = lpc.LADIn;
            cnt_d       = CNT_W'(1);
          end else begin
            data_d[7:4] = lpc.LADIn;
            cnt_d       = '0;
            state_d     = ST_HTAR;
          end
        end
        ST_HTAR: begin
          if (cnt_q == '0) begin
            cnt_d = CNT_W'(1);
          end else begin
            cnt_d     = '0;
            state_d   = ST_SYNC;
            lad_oe_d  = 1'b1;
            lad_out_d = 4'h0;
          end
        end
        ST_SYNC: begin
          if (is_wr_q) begin
            // Echo-port writes complete on the bus but never reach the watchdog.
            if (!is_echo_q) begin
              wd_reg_d = data_q;
              last_d   = data_q;
              strobe_d = 1'b1;
            end
            state_d   = ST_PTAR;
            lad_out_d = 4'hF;
          end else begin
            // Read data is frozen here so RDATA nibbles come from one snapshot.
            data_d    = is_echo_q ? last_q : status_byte;
            lad_out_d = is_echo_q ? last_q[3:0] : status_byte[3:0];
            cnt_d     = '0;
            state_d   = ST_RDATA;
          end
        end
        ST_RDATA: begin
          if (cnt_q == '0) begin
            lad_out_d = data_q[7:4];
            cnt_d     = CNT_W'(1);
          end else begin
            lad_out_d = 4'hF;
            cnt_d     = '0;
            state_d   = ST_PTAR;
          end
        end
        ST_PTAR: begin
          lad_oe_d  = 1'b0;
          lad_out_d = 4'hF;
          state_d   = ST_IDLE;
        end
        ST_IGNORE: ;
        default: begin
          state_d   = ST_IDLE;
          lad_oe_d  = 1'b0;
          lad_out_d = 4'hF;
        end
      endcase
    end
  end

  // State and output registers; reset overrides every same-cycle event.
  always_ff @(posedge LpcClock) begin
    if (Reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      is_wr_q   <= 1'b0;
      is_echo_q <= 1'b0;
      addr_q    <= '0;
      data_q    <= '0;
      lad_oe_q  <= 1'b0;
      lad_out_q <= 4'hF;
      wd_reg_q  <= '0;
      strobe_q  <= 1'b0;
      last_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_wr_q   <= is_wr_d;
      is_echo_q <= is_echo_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      lad_oe_q  <= lad_oe_d;
      lad_out_q <= lad_out_d;
      wd_reg_q  <= wd_reg_d;
      strobe_q  <= strobe_d;
      last_q    <= last_d;
    end
  end

  assign lpc.LADOe      = lad_oe_q;
  assign lpc.LADOut     = lad_out_q;
  assign BiosWDReg      = wd_reg_q;
  assign BiosWDWrStrobe = strobe_q;
  assign LastWrite      = last_q;

endmodule
